// File: rtl/wdf_buf.sv
// Write data buffer between the TLX receive path and the MMIO block.
// TLX receive writes payloads into slots it names. MMIO reads a slot by
// pointer, which frees the slot and returns a credit. Command parity and
// slot-usage errors set sticky fault bits.
module wdf_buf #(
    parameter int DEPTH = 8,
    parameter int DW    = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            tlxr_wdf_wr,
    input  logic [2:0]      tlxr_wdf_wptr,
    input  logic            tlxr_wdf_wr_p,
    input  logic [DW-1:0]   tlxr_wdf_data,
    input  logic [DW/8-1:0] tlxr_wdf_data_p,
    input  logic            mmio_wdf_rd,
    input  logic [2:0]      mmio_wdf_rptr,
    input  logic            mmio_wdf_rd_p,
    output logic [DW-1:0]   wdf_mmio_data,
    output logic [DW/8-1:0] wdf_mmio_data_p,
    output logic            wdf_mmio_data_v,
    output logic            wdf_tlxr_free,
    output logic [2:0]      wdf_tlxr_fptr,
    output logic [3:0]      wdf_cnt,
    output logic [3:0]      wdf_fir
);

    localparam int PW = DW / 8;

    logic [DW-1:0]    mem_data [DEPTH];
    logic [PW-1:0]    mem_par  [DEPTH];
    logic [DEPTH-1:0] valid;

    logic             wr_good;
    logic             wr_bad;
    logic             rd_good;
    logic             rd_bad;
    logic             rd_hit;
    logic             rd_miss;
    logic             overwrite;
    logic [DEPTH-1:0] valid_nxt;
    logic [3:0]       cnt_nxt;
    logic [3:0]       fir_nxt;

    // Decode commands: parity checks, hit/miss and next occupancy state.
    always_comb begin
        wr_good   = tlxr_wdf_wr & ~(^{tlxr_wdf_wr, tlxr_wdf_wptr, tlxr_wdf_wr_p});
        wr_bad    = tlxr_wdf_wr &  (^{tlxr_wdf_wr, tlxr_wdf_wptr, tlxr_wdf_wr_p});
        rd_good   = mmio_wdf_rd &  (^{mmio_wdf_rd, mmio_wdf_rptr, mmio_wdf_rd_p});
        rd_bad    = mmio_wdf_rd & ~(^{mmio_wdf_rd, mmio_wdf_rptr, mmio_wdf_rd_p});
        rd_hit    = rd_good &  valid[mmio_wdf_rptr];
        rd_miss   = rd_good & ~valid[mmio_wdf_rptr];
        // A same-cycle read of the target slot frees it first, so no fault.
        overwrite = wr_good & valid[tlxr_wdf_wptr]
                    & ~(rd_hit & (mmio_wdf_rptr == tlxr_wdf_wptr));

        // Clear before set so a same-slot write+read leaves the slot valid.
        valid_nxt = valid;
        if (rd_hit) begin
            valid_nxt[mmio_wdf_rptr] = 1'b0;
        end
        if (wr_good) begin
            valid_nxt[tlxr_wdf_wptr] = 1'b1;
        end

        // Count is derived from the valid bits so it cannot drift or wrap.
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + 4'(valid_nxt[i]);
        end

        fir_nxt = wdf_fir | {rd_miss, overwrite, rd_bad, wr_bad};
    end

    // Payload array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (!rstn && wr_good) begin
            mem_data[tlxr_wdf_wptr] <= tlxr_wdf_data;
            mem_par[tlxr_wdf_wptr]  <= tlxr_wdf_data_p;
        end
    end

    // Occupancy, fault and registered read/credit outputs.
    always_ff @(posedge clk) begin
        if (rstn) begin
            valid           <= '0;
            wdf_cnt         <= '0;
            wdf_fir         <= '0;
            wdf_mmio_data   <= '0;
            wdf_mmio_data_p <= '0;
            wdf_mmio_data_v <= 1'b0;
            wdf_tlxr_free   <= 1'b0;
            wdf_tlxr_fptr   <= '0;
        end else begin
            valid           <= valid_nxt;
            wdf_cnt         <= cnt_nxt;
            wdf_fir         <= fir_nxt;
            // Array read uses pre-write contents, giving old data on a
            // same-slot write+read.
            wdf_mmio_data   <= rd_hit ? mem_data[mmio_wdf_rptr] : '0;
            wdf_mmio_data_p <= rd_hit ? mem_par[mmio_wdf_rptr]  : '0;
            wdf_mmio_data_v <= rd_good;
            wdf_tlxr_free   <= rd_hit;
            wdf_tlxr_fptr   <= rd_hit ? mmio_wdf_rptr : 3'd0;
        end
    end

endmodule

// File: tb/tb_wdf_buf.sv
// Bench for wdf_buf: directed commands, a slot-table reference model
// compared every cycle, plus literal expectations at key points.
module tb_wdf_buf;

    localparam int DW = 64;
    localparam int PW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr;
    logic [2:0]    wptr;
    logic          wr_p;
    logic [DW-1:0] wdata;
    logic [PW-1:0] wdata_p;
    logic          rd;
    logic [2:0]    rptr;
    logic          rd_p;
    logic [DW-1:0] data;
    logic [PW-1:0] data_p;
    logic          data_v;
    logic          free;
    logic [2:0]    fptr;
    logic [3:0]    cnt;
    logic [3:0]    fir;

    int n_tests = 0;
    int n_fail  = 0;

    wdf_buf #(.DEPTH(8), .DW(DW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .tlxr_wdf_wr     (wr),
        .tlxr_wdf_wptr   (wptr),
        .tlxr_wdf_wr_p   (wr_p),
        .tlxr_wdf_data   (wdata),
        .tlxr_wdf_data_p (wdata_p),
        .mmio_wdf_rd     (rd),
        .mmio_wdf_rptr   (rptr),
        .mmio_wdf_rd_p   (rd_p),
        .wdf_mmio_data   (data),
        .wdf_mmio_data_p (data_p),
        .wdf_mmio_data_v (data_v),
        .wdf_tlxr_free   (free),
        .wdf_tlxr_fptr   (fptr),
        .wdf_cnt         (cnt),
        .wdf_fir         (fir)
    );

    always #5 clk = ~clk;

    // Reference model: a table of slots processed as "read first, then write".
    logic [DW-1:0] m_mem   [8];
    logic [PW-1:0] m_par   [8];
    bit            m_valid [8];
    logic [3:0]    m_fir;
    bit            e_v, e_free;
    logic [DW-1:0] e_data;
    logic [PW-1:0] e_par;
    logic [2:0]    e_fptr;
    bit            armed = 0;

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [PW-1:0] byte_par(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        for (int i = 0; i < PW; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    always @(posedge clk) begin
        bit wr_ok, rd_ok;
        e_v = 0; e_free = 0; e_data = '0; e_par = '0; e_fptr = '0;
        if (rstn === 1'b1) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            m_fir = '0;
            armed = 1;
        end else begin
            wr_ok = wr && ($countones({wr, wptr, wr_p}) % 2 == 0);
            rd_ok = rd && ($countones({rd, rptr, rd_p}) % 2 == 1);
            if (wr && !wr_ok) m_fir[0] = 1'b1;
            if (rd && !rd_ok) m_fir[1] = 1'b1;
            if (rd_ok) begin
                e_v = 1;
                if (m_valid[rptr]) begin
                    e_data = m_mem[rptr];
                    e_par  = m_par[rptr];
                    e_free = 1;
                    e_fptr = rptr;
                    m_valid[rptr] = 0;
                end else begin
                    m_fir[3] = 1'b1;
                end
            end
            if (wr_ok) begin
                if (m_valid[wptr]) m_fir[2] = 1'b1;
                m_mem[wptr]   = wdata;
                m_par[wptr]   = wdata_p;
                m_valid[wptr] = 1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (armed) begin
            n_tests++;
            if (data_v !== e_v || free !== e_free || cnt !== 4'(occupied()) || fir !== m_fir) begin
                n_fail++;
                $display("FAIL model_ctl t=%0t: got v=%b free=%b cnt=%0d fir=%b, want v=%b free=%b cnt=%0d fir=%b",
                         $time, data_v, free, cnt, fir, e_v, e_free, occupied(), m_fir);
            end
            if (e_v) begin
                n_tests++;
                if (data !== e_data || data_p !== e_par) begin
                    n_fail++;
                    $display("FAIL model_data t=%0t: got %h/%h, want %h/%h", $time, data, data_p, e_data, e_par);
                end
            end
            if (e_free) begin
                n_tests++;
                if (fptr !== e_fptr) begin
                    n_fail++;
                    $display("FAIL model_fptr t=%0t: got %0d, want %0d", $time, fptr, e_fptr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // One command cycle; inputs change on the falling edge.
    task automatic cyc(input bit do_wr, input int wp, input bit wbad, input logic [DW-1:0] d,
                       input bit do_rd, input int rp, input bit rbad);
        @(negedge clk);
        #1;
        rstn    = 1'b0;
        wr      = do_wr;
        wptr    = 3'(wp);
        wr_p    = (1'b1 ^ (^wptr)) ^ wbad;
        wdata   = d;
        wdata_p = byte_par(d);
        rd      = do_rd;
        rptr    = 3'(rp);
        rd_p    = (^rptr) ^ rbad;
        if (!do_wr) wr_p = 1'b0;
        if (!do_rd) rd_p = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn = 1'b1; wr = 0; rd = 0; wr_p = 0; rd_p = 0;
        wptr = '0; rptr = '0; wdata = '0; wdata_p = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
    endtask

    initial begin
        rstn = 1'b1; wr = 0; rd = 0; wr_p = 0; rd_p = 0;
        wptr = '0; rptr = '0; wdata = '0; wdata_p = '0;
        do_reset();
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_fir", 64'(fir), 64'd0);
        check("rst_v",   64'(data_v), 64'd0);
        check("rst_free", 64'(free), 64'd0);

        // Write slot 3, read it next cycle.
        cyc(1, 3, 0, 64'h0123456789ABCDEF, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 3, 0);
        #1 check("w3_cnt", 64'(cnt), 64'd1);
        idle();
        #1;
        check("r3_v",    64'(data_v), 64'd1);
        check("r3_data", data, 64'h0123456789ABCDEF);
        check("r3_par",  64'(data_p), 64'(byte_par(64'h0123456789ABCDEF)));
        check("r3_free", 64'(free), 64'd1);
        check("r3_fptr", 64'(fptr), 64'd3);
        check("r3_cnt",  64'(cnt), 64'd0);
        check("r3_fir",  64'(fir), 64'd0);

        // Fill all slots, then read 7..0 back to back.
        for (int i = 0; i < 8; i++) cyc(1, i, 0, 64'(i), 0, 0, 0);
        idle();
        #1 check("fill_cnt", 64'(cnt), 64'd8);
        for (int i = 7; i >= 0; i--) begin
            cyc(0, 0, 0, '0, 1, i, 0);
            if (i < 7) begin
                #1 check("b2b_data", data, 64'(i + 1));
            end
        end
        idle();
        #1 check("b2b_last", data, 64'd0);
        check("b2b_v", 64'(data_v), 64'd1);
        idle();
        #1 check("drain_cnt", 64'(cnt), 64'd0);

        // Overwrite slot 5.
        do_reset();
        cyc(1, 5, 0, 64'hAAAA, 0, 0, 0);
        cyc(1, 5, 0, 64'hBBBB, 0, 0, 0);
        idle();
        #1 check("ow_fir", 64'(fir), 64'b0100);
        check("ow_cnt", 64'(cnt), 64'd1);
        cyc(0, 0, 0, '0, 1, 5, 0);
        idle();
        #1 check("ow_data", data, 64'hBBBB);

        // Read of an empty slot.
        do_reset();
        cyc(0, 0, 0, '0, 1, 2, 0);
        idle();
        #1 check("empty_fir", 64'(fir), 64'b1000);
        check("empty_v",    64'(data_v), 64'd1);
        check("empty_data", data, 64'd0);
        check("empty_free", 64'(free), 64'd0);
        check("empty_cnt",  64'(cnt), 64'd0);

        // Bad command parity on both ports.
        do_reset();
        cyc(1, 1, 1, 64'h1111, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 1);
        idle();
        #1 check("par_fir", 64'(fir), 64'b0011);
        check("par_cnt", 64'(cnt), 64'd0);
        check("par_v",   64'(data_v), 64'd0);
        check("par_free", 64'(free), 64'd0);

        // Same-slot write and read in one cycle, then different slots.
        do_reset();
        cyc(1, 4, 0, 64'hA, 0, 0, 0);
        cyc(1, 4, 0, 64'hB, 1, 4, 0);
        cyc(0, 0, 0, '0, 1, 4, 0);
        #1 check("ss_old", data, 64'hA);
        check("ss_free", 64'(free), 64'd1);
        check("ss_cnt",  64'(cnt), 64'd1);
        idle();
        #1 check("ss_new", data, 64'hB);
        check("ss_fir", 64'(fir), 64'd0);
        cyc(1, 6, 0, 64'hC, 0, 0, 0);
        cyc(1, 2, 0, 64'hD, 1, 6, 0);
        idle();
        #1 check("diff_data", data, 64'hC);
        check("diff_cnt", 64'(cnt), 64'd1);

        // Reset while a read is in flight discards it.
        cyc(0, 0, 0, '0, 1, 2, 0);
        @(negedge clk);
        #1 rstn = 1'b1; rd = 0;
        @(negedge clk);
        #1 check("rst_mid_v", 64'(data_v), 64'd0);
        check("rst_mid_free", 64'(free), 64'd0);
        check("rst_mid_cnt", 64'(cnt), 64'd0);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wdf_buf.md
# wdf_buf

Write data buffer between the TLX receive path and the MMIO block. Holds up to eight 64-bit write payloads in pointer-addressed slots. TLX receive writes each payload into a slot it names; MMIO later reads the slot by pointer, which frees it and returns a credit to TLX receive. Command parity is checked on both ports, and slot-usage protocol errors are logged in sticky fault bits.

## Interface
- DEPTH, 8: number of slots; the pointer width is fixed at 3 bits.
- DW, 64: payload width; always a multiple of 8.
- clk  in  1  the only clock; all state changes on its rising edge.
- rstn  in  1  synchronous, active-high reset (1 = reset, sampled on clk).
- tlxr_wdf_wr  in  1  write strobe, one cycle per payload.
- tlxr_wdf_wptr  in  3  target slot.
- tlxr_wdf_wr_p  in  1  command parity; good when ^{wr,wptr,wr_p}==0 (even).
- tlxr_wdf_data  in  DW  payload.
- tlxr_wdf_data_p  in  DW/8  per-byte even parity of the payload; stored, not checked.
- mmio_wdf_rd  in  1  read strobe.
- mmio_wdf_rptr  in  3  slot to read.
- mmio_wdf_rd_p  in  1  command parity; good when ^{rd,rptr,rd_p}==1 (odd).
- wdf_mmio_data  out  DW  read data, registered.
- wdf_mmio_data_p  out  DW/8  stored byte parity of the read data.
- wdf_mmio_data_v  out  1  read data valid, one-cycle pulse.
- wdf_tlxr_free  out  1  credit-return pulse, one per freed slot.
- wdf_tlxr_fptr  out  3  slot being freed; meaningful only with wdf_tlxr_free.
- wdf_cnt  out  4  occupied slot count, 0..8.
- wdf_fir  out  4  sticky faults: [0] write command parity, [1] read command parity, [2] overwrite of an occupied slot, [3] read of an empty slot.

## Operation
- State: data/parity array DEPTH×(DW+DW/8), valid[DEPTH], output registers, wdf_fir, wdf_cnt.
- Reset (rstn=1 at clk edge): valid=0, wdf_cnt=0, wdf_fir=0, and all outputs 0. Array contents are don't-care.
- Good write (wr=1, parity good):
  - Stores data and data_p into slot wptr and sets valid[wptr].
  - If valid[wptr] was already 1 and no same-cycle read of that slot frees it: set wdf_fir[2]. The slot is still overwritten and wdf_cnt does not increase.
- Bad write parity (wr=1, parity bad): set wdf_fir[0]. The command is dropped: no array, valid or count change.
- Good read (rd=1, parity good, valid[rptr]=1):
  - Next cycle: data_v=1 with the stored data and parity, free=1, fptr=rptr.
  - Clears valid[rptr].
- Good read of an empty slot (valid[rptr]=0):
  - Sets wdf_fir[3].
  - Next cycle: data_v=1 with data=0 and data_p=0; free=0.
- Bad read parity: set wdf_fir[1]. The command is dropped: no data_v, no free.
- Write and good read to the same valid slot in one cycle: the read returns the old contents and frees the slot; the write lands, so the slot ends valid with new data. No overwrite fault, wdf_cnt unchanged, and free still pulses.
- Write and read to different slots in one cycle: both take effect independently.
- wdf_cnt = number of set valid bits. +1 per good write to an empty slot, −1 per good read of a valid slot, net 0 when both occur. Never wraps past 8 or below 0.
- wdf_fir bits stay set until reset.

## Timing
- Read latency is 1 cycle: rd sampled at edge N gives data_v/data/free/fptr at edge N+1. Outputs are registered with no combinational path from inputs.
- Back-to-back reads every cycle are supported at full rate; data_v and free pulse in consecutive cycles.
- Write-to-read: a write at edge N is readable by a read sampled at edge N+1. A same-edge read sees the pre-write contents.
- Fault bits and wdf_cnt update at the edge that samples the offending or causing command.
- Reset mid-operation: a read pending in the output stage is discarded, so data_v and free are 0 in the cycle after reset. No credits are returned for slots lost at reset; TLX receive resets its credits concurrently.

## Test plan
- Reset, then write slot 3 with data 0x0123456789ABCDEF and good parity, then read slot 3 next cycle -> data_v=1 with that data, free=1, fptr=3; wdf_cnt goes 0→1→0; wdf_fir=0.
- Fill all 8 slots with data = slot index, then read 7..0 back-to-back -> eight consecutive data_v pulses returning 7..0 in order; wdf_cnt 8→0; eight free pulses.
- Write slot 5 twice without a read -> wdf_fir=4'b0100, wdf_cnt=1, and a read returns the second payload.
- Read empty slot 2 -> wdf_fir[3]=1, data_v=1 with data 0, free=0, wdf_cnt unchanged.
- Write slot 1 with wr_p flipped, then read slot 0 with rd_p flipped -> wdf_fir=4'b0011, no slot written, no data_v, no free.
- Slot 4 holds A; in one cycle write B to slot 4 and read slot 4 -> next cycle data=A and free=1; a following read returns B; no fir bits set.
